// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch controller
// (master) and the instruction memory (slave).
interface fetch_ctrl_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_gnt_i,
      input  imem_rvalid_i,
      input  imem_rdata_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_gnt_i,
      output imem_rvalid_i,
      output imem_rdata_i
   );
endinterface

// File: rtl/fetch_ctrl.sv
// IF-stage fetch controller with IF/ID pipeline register.
// Issues in-order requests to instruction memory, buffers returned words in a
// small FIFO (each word tagged with the PC it was fetched from), squashes
// wrong-path responses after a redirect and feeds {pc, instr, valid} to ID.
// Optional feature: define FETCH_BYPASS_EN to let a returning word go straight
// into IF/ID when the FIFO is empty, saving one cycle of fetch latency.

// Protocol checker: the issue cap must keep the FIFO from overflowing, and
// memory must never answer a request that was not issued.
module fetch_ctrl_chk #(
   parameter int CW = 2
) (
   input logic          clk,
   input logic          rst_n,
   input logic          push,
   input logic          full,
   input logic          rvalid,
   input logic [CW-1:0] out_cnt
);
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
   a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
                                     !(rvalid && (out_cnt == {CW{1'b0}})));
endmodule

module fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         pc_wren_i,
   input  logic         IFID_wren_i,
   input  logic         IFID_clear_i,
   input  logic         br_flush_i,
   input  logic [31:0]  br_target_i,
   fetch_ctrl_if.master imem,
   output logic [31:0]  IFID_pc_o,
   output logic [31:0]  IFID_instr_o,
   output logic         IFID_valid_o,
   output logic         fetch_empty_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   pc_r;
   logic [CW-1:0] out_cnt_r;
   logic [CW-1:0] drop_cnt_r;

   logic [31:0]   fifo_instr_r [FIFO_DEPTH];
   logic [31:0]   fifo_pc_r    [FIFO_DEPTH];
   logic [CW-1:0] fifo_wr_r;
   logic [CW-1:0] fifo_rd_r;

   // PCs of issued, not-yet-answered, non-squashed requests in issue order
   logic [31:0]   tag_pc_r [FIFO_DEPTH];
   logic [CW-1:0] tag_wr_r;
   logic [CW-1:0] tag_rd_r;

   logic [31:0]   ifid_pc_r;
   logic [31:0]   ifid_instr_r;
   logic          ifid_valid_r;

   logic [CW-1:0] fifo_cnt_s;
   logic          fifo_empty_s;
   logic          fifo_full_s;
   logic [CW:0]   in_use_s;
   logic          cap_ok_s;
   logic          req_s;
   logic          issue_s;
   logic          resp_keep_s;
   logic          bypass_s;
   logic          push_s;
   logic          pop_s;
   logic [31:0]   tag_head_s;
   logic [CW-1:0] drop_next_s;
   logic [CW-1:0] out_next_s;

   assign fifo_cnt_s   = fifo_wr_r - fifo_rd_r;
   assign fifo_empty_s = (fifo_cnt_s == {CW{1'b0}});
   assign fifo_full_s  = (fifo_cnt_s == CW'(FIFO_DEPTH));
   // Outstanding requests plus buffered words may never exceed the FIFO size,
   // so every response always has a slot waiting for it.
   assign in_use_s     = {1'b0, out_cnt_r} + {1'b0, fifo_cnt_s};
   assign cap_ok_s     = (in_use_s < (CW+1)'(FIFO_DEPTH));
   assign req_s        = rst_ni & pc_wren_i & ~br_flush_i & cap_ok_s;
   assign issue_s      = req_s & imem.imem_gnt_i;
   // A response is kept only if it belongs to the current path; the one
   // arriving in the flush cycle itself is always discarded.
   assign resp_keep_s  = imem.imem_rvalid_i & ~br_flush_i & (drop_cnt_r == {CW{1'b0}});
   assign tag_head_s   = tag_pc_r[tag_rd_r[AW-1:0]];

`ifdef FETCH_BYPASS_EN
   assign bypass_s = resp_keep_s & fifo_empty_s & IFID_wren_i & ~IFID_clear_i;
`else
   assign bypass_s = 1'b0;
`endif

   assign push_s = resp_keep_s & ~bypass_s;
   assign pop_s  = ~br_flush_i & ~IFID_clear_i & IFID_wren_i & ~fifo_empty_s;

   assign imem.imem_req_o  = req_s;
   assign imem.imem_addr_o = pc_r;
   assign IFID_pc_o        = ifid_pc_r;
   assign IFID_instr_o     = ifid_instr_r;
   assign IFID_valid_o     = ifid_valid_r;
   assign fetch_empty_o    = fifo_empty_s & ~bypass_s;

   // Next values of the in-flight and to-be-dropped response counters
   always_comb begin
      out_next_s  = out_cnt_r + CW'(issue_s) - CW'(imem.imem_rvalid_i);
      drop_next_s = drop_cnt_r;
      if (br_flush_i) begin
         // every response still owed after this cycle belongs to the old path
         drop_next_s = out_cnt_r - CW'(imem.imem_rvalid_i);
      end else if (imem.imem_rvalid_i && (drop_cnt_r != {CW{1'b0}})) begin
         drop_next_s = drop_cnt_r - CW'(1);
      end else begin
         drop_next_s = drop_cnt_r;
      end
   end

   // Program counter: redirect beats issue; stays put while a request waits for grant
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_r <= RESET_PC;
      end else if (br_flush_i) begin
         pc_r <= br_target_i & 32'hFFFF_FFFC;
      end else if (issue_s) begin
         pc_r <= pc_r + 32'd4;
      end else begin
         pc_r <= pc_r;
      end
   end

   // Outstanding-request and drop counters
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_cnt_r  <= {CW{1'b0}};
         drop_cnt_r <= {CW{1'b0}};
      end else begin
         out_cnt_r  <= out_next_s;
         drop_cnt_r <= drop_next_s;
      end
   end

   // PC tag queue: pushed at issue, popped when a kept response returns
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tag_wr_r <= {CW{1'b0}};
         tag_rd_r <= {CW{1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            tag_pc_r[i] <= 32'h0000_0000;
         end
      end else if (br_flush_i) begin
         tag_wr_r <= {CW{1'b0}};
         tag_rd_r <= {CW{1'b0}};
      end else begin
         if (issue_s) begin
            tag_pc_r[tag_wr_r[AW-1:0]] <= pc_r;
            tag_wr_r <= tag_wr_r + CW'(1);
         end
         if (resp_keep_s) begin
            tag_rd_r <= tag_rd_r + CW'(1);
         end
      end
   end

   // Response FIFO holding {pc, instr}; emptied on redirect
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fifo_wr_r <= {CW{1'b0}};
         fifo_rd_r <= {CW{1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_instr_r[i] <= 32'h0000_0000;
            fifo_pc_r[i]    <= 32'h0000_0000;
         end
      end else if (br_flush_i) begin
         fifo_wr_r <= {CW{1'b0}};
         fifo_rd_r <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            fifo_instr_r[fifo_wr_r[AW-1:0]] <= imem.imem_rdata_i;
            fifo_pc_r[fifo_wr_r[AW-1:0]]    <= tag_head_s;
            fifo_wr_r <= fifo_wr_r + CW'(1);
         end
         if (pop_s) begin
            fifo_rd_r <= fifo_rd_r + CW'(1);
         end
      end
   end

   // IF/ID register: bubble on flush/clear, hold on stall, else load next word
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ifid_pc_r    <= 32'h0000_0000;
         ifid_instr_r <= NOP_INSTR;
         ifid_valid_r <= 1'b0;
      end else if (br_flush_i || IFID_clear_i) begin
         ifid_instr_r <= NOP_INSTR;
         ifid_valid_r <= 1'b0;
      end else if (!IFID_wren_i) begin
         ifid_valid_r <= ifid_valid_r;
      end else if (!fifo_empty_s) begin
         ifid_pc_r    <= fifo_pc_r[fifo_rd_r[AW-1:0]];
         ifid_instr_r <= fifo_instr_r[fifo_rd_r[AW-1:0]];
         ifid_valid_r <= 1'b1;
      end else if (bypass_s) begin
         ifid_pc_r    <= tag_head_s;
         ifid_instr_r <= imem.imem_rdata_i;
         ifid_valid_r <= 1'b1;
      end else begin
         ifid_instr_r <= NOP_INSTR;
         ifid_valid_r <= 1'b0;
      end
   end

   fetch_ctrl_chk #(.CW(CW)) u_chk (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .push    (push_s),
      .full    (fifo_full_s),
      .rvalid  (imem.imem_rvalid_i),
      .out_cnt (out_cnt_r)
   );
endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a behavioural memory answers requests in
// order with configurable latency; the reference model predicts the fetched
// program stream (sequential PCs, restarted at each redirect) and the IF/ID
// contents on hold/bubble.
module tb_fetch_ctrl;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam int          DEPTH    = 2;
`ifdef FETCH_BYPASS_EN
   localparam int LAT_EXP = 2;
`else
   localparam int LAT_EXP = 3;
`endif

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b1;
   logic        pc_wren_i = 1'b1;
   logic        IFID_wren_i = 1'b1;
   logic        IFID_clear_i = 1'b0;
   logic        br_flush_i = 1'b0;
   logic [31:0] br_target_i = 32'h0;
   logic [31:0] IFID_pc_o;
   logic [31:0] IFID_instr_o;
   logic        IFID_valid_o;
   logic        fetch_empty_o;

   fetch_ctrl_if imem ();

   fetch_ctrl #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .pc_wren_i    (pc_wren_i),
      .IFID_wren_i  (IFID_wren_i),
      .IFID_clear_i (IFID_clear_i),
      .br_flush_i   (br_flush_i),
      .br_target_i  (br_target_i),
      .imem         (imem),
      .IFID_pc_o    (IFID_pc_o),
      .IFID_instr_o (IFID_instr_o),
      .IFID_valid_o (IFID_valid_o),
      .fetch_empty_o(fetch_empty_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC3A5_0000;
   endfunction

   // ---------------- behavioural instruction memory ----------------
   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;
   pend_t pend[$];
   int    cyc = 0;
   int    mem_lat = 1;
   int    gnt_pct = 100;
   bit    gnt_low = 1'b0;

   initial begin
      pend_t p;
      imem.imem_gnt_i    = 1'b0;
      imem.imem_rvalid_i = 1'b0;
      imem.imem_rdata_i  = 32'h0;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            pend.delete();
         end else begin
            if (imem.imem_rvalid_i && pend.size() > 0) void'(pend.pop_front());
            if (imem.imem_req_o && imem.imem_gnt_i) begin
               p.addr = imem.imem_addr_o;
               p.due  = cyc + mem_lat;
               pend.push_back(p);
            end
         end
         @(posedge clk_i);
         #1;
         cyc++;
         if (rst_ni && pend.size() > 0 && pend[0].due <= cyc) begin
            imem.imem_rvalid_i = 1'b1;
            imem.imem_rdata_i  = mem_word(pend[0].addr);
         end else begin
            imem.imem_rvalid_i = 1'b0;
            imem.imem_rdata_i  = 32'h0;
         end
         imem.imem_gnt_i = (!gnt_low && ($urandom_range(0, 99) < gnt_pct));
      end
   end

   // ---------------- reference model + monitor ----------------
   logic [31:0] exp_q[$];
   logic [31:0] model_pc = RESET_PC;
   logic [31:0] last_pc = 32'h0;
   logic [31:0] last_instr = NOP;
   logic        last_valid = 1'b0;
   bit          loaded_p = 1'b0, bub_p = 1'b0, hold_p = 1'b0;
   int          issued = 0;
   int          loads = 0;

   always @(negedge clk_i) begin
      logic [31:0] e;
      if (!rst_ni) begin
         exp_q.delete();
         model_pc = RESET_PC;
         last_pc = 32'h0; last_instr = NOP; last_valid = 1'b0;
         loaded_p = 1'b0; bub_p = 1'b0; hold_p = 1'b0;
         chk("rst_req", imem.imem_req_o, 1'b0);
         chk("rst_addr", imem.imem_addr_o, RESET_PC);
         chk("rst_ifid_pc", IFID_pc_o, 32'h0);
         chk("rst_ifid_instr", IFID_instr_o, NOP);
         chk("rst_ifid_valid", IFID_valid_o, 1'b0);
         chk("rst_empty", fetch_empty_o, 1'b1);
      end else begin
         // outputs produced by the previous edge
         if (bub_p) begin
            chk("bubble_valid", IFID_valid_o, 1'b0);
            chk("bubble_instr", IFID_instr_o, NOP);
            chk("bubble_pc", IFID_pc_o, last_pc);
            last_valid = 1'b0; last_instr = NOP;
         end else if (hold_p) begin
            chk("hold_valid", IFID_valid_o, last_valid);
            chk("hold_pc", IFID_pc_o, last_pc);
            chk("hold_instr", IFID_instr_o, last_instr);
         end else if (loaded_p) begin
            if (IFID_valid_o) begin
               if (exp_q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL unexpected_instr: got pc %h, required no instruction", IFID_pc_o);
               end else begin
                  e = exp_q.pop_front();
                  chk("ifid_pc", IFID_pc_o, e);
                  chk("ifid_instr", IFID_instr_o, mem_word(e));
                  loads++;
               end
               last_pc = IFID_pc_o; last_instr = IFID_instr_o; last_valid = 1'b1;
            end else begin
               chk("empty_bubble_instr", IFID_instr_o, NOP);
               chk("empty_bubble_pc", IFID_pc_o, last_pc);
               last_valid = 1'b0; last_instr = NOP;
            end
         end
         // this cycle's inputs decide the next edge
         bub_p    = IFID_clear_i | br_flush_i;
         hold_p   = ~bub_p & ~IFID_wren_i;
         loaded_p = ~bub_p & IFID_wren_i;
         if (!pc_wren_i || br_flush_i) chk("req_blocked", imem.imem_req_o, 1'b0);
         if (br_flush_i) begin
            exp_q.delete();
            model_pc = br_target_i & 32'hFFFF_FFFC;
         end else if (imem.imem_req_o) begin
            chk("req_addr", imem.imem_addr_o, model_pc);
            if (imem.imem_gnt_i) begin
               exp_q.push_back(model_pc);
               model_pc = model_pc + 32'd4;
               issued++;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit pw, input bit iw, input bit cl, input bit fl,
                        input logic [31:0] tg);
      @(posedge clk_i);
      #2;
      pc_wren_i = pw; IFID_wren_i = iw; IFID_clear_i = cl;
      br_flush_i = fl; br_target_i = tg;
   endtask

   initial begin
      int  first;
      bit  found;
      int  stall_left;
      bit  pw, iw;
      #1 rst_ni = 1'b0;
      repeat (3) @(posedge clk_i);
      #2 rst_ni = 1'b1;

      // fetch latency from reset release, zero-wait memory
      first = -1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk_i);
         if (IFID_valid_o && first < 0) first = k;
      end
      chk("first_valid_cycle", first, LAT_EXP);
      repeat (12) drive(1, 1, 0, 0, 32'h0);

      // load-use stall for 3 cycles, then resume
      repeat (3) drive(0, 0, 0, 0, 32'h0);
      repeat (10) drive(1, 1, 0, 0, 32'h0);

      // latency-3 memory, redirect with requests in flight
      mem_lat = 3;
      repeat (5) drive(1, 1, 0, 0, 32'h0);
      drive(1, 1, 0, 1, 32'h0000_0100);
      repeat (15) drive(1, 1, 0, 0, 32'h0);

      // redirect coincident with a response while PC is stalled
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(posedge clk_i);
         #2;
         if (imem.imem_rvalid_i) begin
            pc_wren_i = 1'b0; br_flush_i = 1'b1; br_target_i = 32'h0000_0100;
            found = 1'b1;
         end else begin
            pc_wren_i = 1'b1; br_flush_i = 1'b0;
         end
      end
      chk("flush_rvalid_found", found, 1'b1);
      repeat (15) drive(1, 1, 0, 0, 32'h0);

      // grant withheld: pipeline drains and stays empty
      gnt_low = 1'b1;
      for (int k = 0; k < 12; k++) begin
         drive(1, 1, 0, 0, 32'h0);
         @(negedge clk_i);
         if (k >= 8) begin
            chk("gntlow_valid", IFID_valid_o, 1'b0);
            chk("gntlow_empty", fetch_empty_o, 1'b1);
         end
      end
      gnt_low = 1'b0;

      // randomized traffic
      gnt_pct = 70;
      stall_left = 0;
      for (int i = 0; i < 400; i++) begin
         if (i % 100 == 0) mem_lat = $urandom_range(1, 3);
         if (stall_left > 0) begin
            pw = 1'b0; iw = 1'b0; stall_left--;
         end else begin
            if ($urandom_range(0, 99) < 6) stall_left = 3;
            pw = ($urandom_range(0, 9) != 0);
            iw = ($urandom_range(0, 9) != 0);
         end
         drive(pw, iw, ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 4),
               $urandom & 32'h0000_3FFF);
      end

      // reset with requests outstanding
      gnt_pct = 100;
      mem_lat = 3;
      repeat (6) drive(1, 1, 0, 0, 32'h0);
      @(posedge clk_i);
      #2 rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #2 rst_ni = 1'b1;
      @(negedge clk_i);
      chk("post_rst_req", imem.imem_req_o, 1'b1);
      chk("post_rst_addr", imem.imem_addr_o, RESET_PC);
      repeat (20) drive(1, 1, 0, 0, 32'h0);

      // drain: no more issue, everything owed must arrive
      repeat (20) drive(0, 1, 0, 0, 32'h0);
      @(negedge clk_i);
      chk("drain_queue_left", exp_q.size(), 32'd0);
      chk("issued_enough", (issued > 50), 1'b1);
      chk("loads_enough", (loads > 50), 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
